// File: rtl/tamagotchi_pkg.sv
// tamagotchi_pkg: state codes shared with the state controller and saturating need arithmetic.
package tamagotchi_pkg;
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] DORMINDO   = 4'd1;
    localparam logic [3:0] COMENDO    = 4'd2;
    localparam logic [3:0] DANDO_AULA = 4'd3;
    localparam logic [3:0] MORTO      = 4'd4;

    function automatic int satura(input int v, input int maxv);
        return (v > maxv) ? maxv : ((v < 0) ? 0 : v);
    endfunction
endpackage

// File: rtl/divisor_tick.sv
// divisor_tick: divides clk into a registered one-cycle tick every TICK_DIV cycles.
module divisor_tick #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] r_cnt;
    // tick is registered one cycle early so it is high while r_cnt sits at TICK_DIV-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else begin
            r_cnt <= (r_cnt == CW'(TICK_DIV - 1)) ? '0 : r_cnt + 1'b1;
            tick  <= (r_cnt == CW'(TICK_DIV - 2));
        end
    end
endmodule

// File: rtl/gerenciador_necessidades.sv
// gerenciador_necessidades: per-tick saturating vitals (fome, cansaco, tedio) and sticky death flag.
// Optional ALERTA_EN adds a registered alerta output for needs at or above MAX-2.
module gerenciador_necessidades
    import tamagotchi_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int W        = 4,
    parameter int INICIAL  = 0,
    parameter int LIMIAR   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   estado,
    output logic [W-1:0] fome,
    output logic [W-1:0] cansaco,
    output logic [W-1:0] tedio,
    output logic         tick,
    output logic         morreu
`ifdef ALERTA_EN
    ,
    output logic         alerta
`endif
);
    localparam int           MAX = 2**W - 1;
    localparam logic [7:0]   LIM = 8'(LIMIAR);
    logic         w_tick, w_upd, w_crit, w_morreu_n;
    int           w_df, w_dc, w_dt;
    logic [W-1:0] w_fome_n, w_cansaco_n, w_tedio_n;
    logic [7:0]   r_crit_cnt, w_crit_n;

    divisor_tick #(.TICK_DIV(TICK_DIV)) u_div (.clk(clk), .rst(rst), .tick(w_tick));
    assign tick = w_tick;

    always_comb begin
        w_df = (estado == COMENDO) ? -2 :
               (estado == IDLE || estado == DORMINDO || estado == DANDO_AULA) ? 1 : 0;
        w_dc = (estado == IDLE || estado == COMENDO) ? 1 :
               (estado == DORMINDO) ? -2 : (estado == DANDO_AULA) ? 2 : 0;
        w_dt = (estado == IDLE || estado == COMENDO) ? 1 : (estado == DANDO_AULA) ? -2 : 0;
        w_upd       = w_tick && !morreu && estado != MORTO;
        w_fome_n    = W'(satura(int'(fome) + w_df, MAX));
        w_cansaco_n = W'(satura(int'(cansaco) + w_dc, MAX));
        w_tedio_n   = W'(satura(int'(tedio) + w_dt, MAX));
        w_crit      = (&w_fome_n) | (&w_cansaco_n) | (&w_tedio_n);
        w_crit_n    = !w_crit ? 8'd0 : (r_crit_cnt >= LIM) ? LIM : r_crit_cnt + 8'd1;
        w_morreu_n  = morreu | (w_upd && w_crit_n == LIM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fome       <= W'(INICIAL);
            cansaco    <= W'(INICIAL);
            tedio      <= W'(INICIAL);
            r_crit_cnt <= '0;
            morreu     <= 1'b0;
        end else if (w_upd) begin
            fome       <= w_fome_n;
            cansaco    <= w_cansaco_n;
            tedio      <= w_tedio_n;
            r_crit_cnt <= w_crit_n;
            morreu     <= w_morreu_n;
        end
    end

`ifdef ALERTA_EN
    localparam logic [W-1:0] ALV = W'(MAX - 2);
    logic [W-1:0] w_fa, w_ca, w_ta;
    always_comb begin
        w_fa = w_upd ? w_fome_n : fome;
        w_ca = w_upd ? w_cansaco_n : cansaco;
        w_ta = w_upd ? w_tedio_n : tedio;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            alerta <= 1'b0;
        else if (w_tick)
            alerta <= !w_morreu_n && (w_fa >= ALV || w_ca >= ALV || w_ta >= ALV);
    end
`endif
endmodule

// File: tb/tb_gerenciador_necessidades.sv
// tb_gerenciador_necessidades: table-driven and directed checks of the vitals scheduler (TICK_DIV=4, W=4).
module tb_gerenciador_necessidades;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] estado = 4'd0;
    logic [3:0] fome, cansaco, tedio;
    logic       tick, morreu;
`ifdef ALERTA_EN
    logic       alerta;
`endif
    int total = 0;
    int bad = 0;
    int waited = 0;

    localparam logic [3:0] IDLE = 4'd0, DORM = 4'd1, COM = 4'd2, DA = 4'd3, MORTO = 4'd4;

    gerenciador_necessidades #(.TICK_DIV(4), .W(4), .INICIAL(0), .LIMIAR(3)) dut (
        .clk(clk), .rst(rst), .estado(estado), .fome(fome), .cansaco(cansaco),
        .tedio(tedio), .tick(tick), .morreu(morreu)
`ifdef ALERTA_EN
        , .alerta(alerta)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] est;
        int         f;
        int         c;
        int         t;
        bit         m;
    } vec_t;
    vec_t tbl[22];

    task automatic cmp(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset(input logic [3:0] est);
        @(negedge clk);
        estado = est;
        rst = 1'b1;
        #1;
        cmp("rst_fome", fome, 0);
        cmp("rst_cansaco", cansaco, 0);
        cmp("rst_tedio", tedio, 0);
        cmp("rst_tick", tick, 0);
        cmp("rst_morreu", morreu, 0);
`ifdef ALERTA_EN
        cmp("rst_alerta", alerta, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input string nm, input logic [3:0] est, input int ef, input int ec,
                        input int et, input bit em);
        bit seen;
        seen = 1'b0;
        estado = est;
        waited = 0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            waited++;
            seen = tick;
        end
        cmp({nm, "_tick_seen"}, seen, 1);
        @(posedge clk);
        #1;
        cmp({nm, "_fome"}, fome, ef);
        cmp({nm, "_cansaco"}, cansaco, ec);
        cmp({nm, "_tedio"}, tedio, et);
        cmp({nm, "_morreu"}, morreu, em);
        cmp({nm, "_tick_fall"}, tick, 0);
`ifdef ALERTA_EN
        cmp({nm, "_alerta"}, alerta, int'(!em && (ef >= 13 || ec >= 13 || et >= 13)));
`endif
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            tbl[i] = '{IDLE, (i + 1 > 15) ? 15 : i + 1, (i + 1 > 15) ? 15 : i + 1,
                       (i + 1 > 15) ? 15 : i + 1, 1'b0};
        end
        tbl[16] = '{IDLE, 15, 15, 15, 1'b1};
        for (int i = 17; i < 22; i++) tbl[i] = '{COM, 15, 15, 15, 1'b1};

        do_reset(IDLE);
        for (int i = 0; i < 22; i++) begin
            step("ramp", tbl[i].est, tbl[i].f, tbl[i].c, tbl[i].t, tbl[i].m);
            cmp("ramp_period", waited, (i == 0) ? 3 : 4);
        end

        do_reset(IDLE);
        step("sat_idle", IDLE, 1, 1, 1, 0);
        step("sat_com", COM, 0, 2, 2, 0);
        step("morto_hold", MORTO, 0, 2, 2, 0);
        step("undef_hold", 4'd9, 0, 2, 2, 0);

        do_reset(DA);
        for (int k = 1; k <= 7; k++) step("da_ramp", DA, k, 2 * k, 0, 0);
        step("da_sat", DA, 8, 15, 0, 0);
        step("dorm_clr", DORM, 9, 13, 0, 0);
        step("crit_a1", DA, 10, 15, 0, 0);
        step("crit_a2", DA, 11, 15, 0, 0);
        step("crit_clr", DORM, 12, 13, 0, 0);
        step("crit_b1", DA, 13, 15, 0, 0);
        step("crit_b2", DA, 14, 15, 0, 0);
        step("crit_b3", DA, 15, 15, 0, 1);

        do_reset(COM);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        cmp("toggle_tick", tick, 1);
        estado = IDLE;
        @(posedge clk);
        #1;
        cmp("toggle_fome", fome, 1);
        cmp("toggle_cansaco", cansaco, 1);
        cmp("toggle_tedio", tedio, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        cmp("mid_rst_fome", fome, 0);
        cmp("mid_rst_cansaco", cansaco, 0);
        cmp("mid_rst_tedio", tedio, 0);
        cmp("mid_rst_tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;
        step("after_mid_rst", IDLE, 1, 1, 1, 0);
        cmp("after_mid_rst_period", waited, 3);

        do_reset(DORM);
        for (int k = 1; k <= 14; k++) step("alert_ramp", DORM, k, 0, 0, 0);
        step("alert_drop", COM, 12, 1, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
